// File: rtl/recv_buff_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : recv_buff_ctrl
//  Purpose  : Arbitrates network writes and core tag reads onto a receive
//             buffer, retrying missed reads after a fixed gap until a limit.
//  Revision : 1.0 - initial release
// ============================================================================
module recv_buff_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 8,
    parameter int MAX_RETRY  = 15,
    parameter int RETRY_GAP  = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  net_valid,
    output logic                  net_ready,
    input  logic [TAG_WIDTH-1:0]  net_tag,
    input  logic [DATA_WIDTH-1:0] net_data,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [TAG_WIDTH-1:0]  rd_tag,
    output logic                  rd_resp_valid,
    output logic [DATA_WIDTH-1:0] rd_resp_data,
    output logic                  rd_resp_err,
    output logic                  rb_ren,
    output logic                  rb_wen,
    output logic [TAG_WIDTH-1:0]  rb_tag,
    output logic [DATA_WIDTH-1:0] rb_data,
    input  logic                  rb_hit,
    input  logic [DATA_WIDTH-1:0] rb_data_out,
    input  logic                  rb_full,
    input  logic                  rb_empty
);

    localparam logic [3:0] c_retry_last = 4'(MAX_RETRY - 1);
    localparam logic [3:0] c_gap_load   = 4'(RETRY_GAP);

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rd_pend;
    logic                  w_rd_pend_nxt;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [TAG_WIDTH-1:0]  w_tag_nxt;
    logic [3:0]            r_retry_cnt;
    logic [3:0]            w_retry_nxt;
    logic [3:0]            r_gap_cnt;
    logic [3:0]            w_gap_nxt;
    logic                  r_last_grant;
    logic                  w_last_nxt;

    logic                  w_in_arb;
    logic                  w_rd_accept;
    logic                  w_rd_grant;
    logic                  w_wr;

    // Handshakes are gated by nrst so every output reads 0 while in reset.
    assign w_in_arb     = (r_state == ARB);
    assign rd_req_ready = nrst & ~r_rd_pend & w_in_arb;
    assign w_rd_accept  = rd_req_valid & rd_req_ready;
    assign w_rd_grant   = nrst & w_in_arb & r_rd_pend & (r_gap_cnt == 4'd0) &
                          ~rb_empty & (r_last_grant | ~net_valid);
    assign net_ready    = nrst & ~rb_full & ~w_rd_grant;
    assign w_wr         = net_valid & net_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ARB;
            r_rd_pend    <= 1'b0;
            r_tag        <= '0;
            r_retry_cnt  <= 4'd0;
            r_gap_cnt    <= 4'd0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_pend    <= w_rd_pend_nxt;
            r_tag        <= w_tag_nxt;
            r_retry_cnt  <= w_retry_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rd_pend_nxt = r_rd_pend;
        w_tag_nxt     = r_tag;
        w_retry_nxt   = r_retry_cnt;
        w_gap_nxt     = r_gap_cnt;
        w_last_nxt    = r_last_grant;
        rd_resp_valid = 1'b0;
        rd_resp_data  = '0;
        rd_resp_err   = 1'b0;
        rb_ren        = 1'b0;
        rb_wen        = 1'b0;
        rb_tag        = '0;
        rb_data       = '0;

        // Writes are independent of state; the read grant already blocks them.
        if (w_wr) begin
            rb_wen     = 1'b1;
            rb_tag     = net_tag;
            rb_data    = net_data;
            w_last_nxt = 1'b1;
        end

        case (r_state)
            ARB: begin
                if (r_gap_cnt != 4'd0) begin
                    w_gap_nxt = r_gap_cnt - 4'd1;
                end
                if (w_rd_accept) begin
                    w_rd_pend_nxt = 1'b1;
                    w_tag_nxt     = rd_tag;
                    w_retry_nxt   = 4'd0;
                    w_gap_nxt     = 4'd0;
                end
                if (w_rd_grant) begin
                    rb_ren      = 1'b1;
                    rb_tag      = r_tag;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                w_state_nxt = ARB;
                if (rb_hit) begin
                    rd_resp_valid = 1'b1;
                    rd_resp_data  = rb_data_out;
                    w_rd_pend_nxt = 1'b0;
                end else if (r_retry_cnt == c_retry_last) begin
                    rd_resp_valid = 1'b1;
                    rd_resp_err   = 1'b1;
                    w_rd_pend_nxt = 1'b0;
                end else begin
                    w_retry_nxt = r_retry_cnt + 4'd1;
                    w_gap_nxt   = c_gap_load;
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

endmodule
`default_nettype wire
